// File: rtl/march_bist.sv
// March C- self-test engine for a single-port synchronous SRAM, muxed in front of the functional port.
// Optional build macro BIST_STOP_ON_FAIL_EN: halt the test on the first miscompare.
`timescale 1ns/1ps

module march_bist #(
  parameter int unsigned             ADDR_WIDTH     = 8,
  parameter int unsigned             DATA_WIDTH     = 4,
  parameter logic [DATA_WIDTH-1:0]   BACKGROUND     = '0,
  parameter int unsigned             FAIL_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      func_we,
  input  logic [ADDR_WIDTH-1:0]     func_addr,
  input  logic [DATA_WIDTH-1:0]     func_din,
  output logic                      sram_we,
  output logic [ADDR_WIDTH-1:0]     sram_addr,
  output logic [DATA_WIDTH-1:0]     sram_din,
  input  logic [DATA_WIDTH-1:0]     sram_dout,
  output logic                      busy,
  output logic                      done,
  output logic                      fail,
  output logic [ADDR_WIDTH-1:0]     fail_addr,
  output logic [FAIL_CNT_WIDTH-1:0] fail_count
);

  localparam int unsigned ELEM_WIDTH = 3;

  localparam logic [ADDR_WIDTH-1:0]     ADDR_MAX  = '1;
  localparam logic [FAIL_CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [ELEM_WIDTH-1:0]     ELEM_LAST = ELEM_WIDTH'(5);

`ifdef BIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state;
  logic [ELEM_WIDTH-1:0]   elem;
  logic                    phase;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    start_q;
  logic                    cmp_valid;
  logic [DATA_WIDTH-1:0]   cmp_exp;
  logic [ADDR_WIDTH-1:0]   cmp_addr;

  logic                    two_op_c;
  logic                    down_c;
  logic                    op_we_c;
  logic [DATA_WIDTH-1:0]   op_data_c;
  logic                    last_addr_c;
  logic                    step_c;
  logic                    next_down_c;
  logic                    miscmp_c;
  logic                    halt_c;

  // Decode the current March operation from element, phase and address.
  always_comb begin
    two_op_c    = 1'b0;
    down_c      = 1'b0;
    op_we_c     = 1'b0;
    op_data_c   = BACKGROUND;
    next_down_c = 1'b0;

    two_op_c    = (elem >= ELEM_WIDTH'(1)) && (elem <= ELEM_WIDTH'(4));
    down_c      = (elem == ELEM_WIDTH'(3)) || (elem == ELEM_WIDTH'(4));
    next_down_c = (elem == ELEM_WIDTH'(2)) || (elem == ELEM_WIDTH'(3));
    op_we_c     = (elem == ELEM_WIDTH'(0)) || (two_op_c && phase);

    if (op_we_c) begin
      // Writes of logical 1 happen in E1 and E3.
      if ((elem == ELEM_WIDTH'(1)) || (elem == ELEM_WIDTH'(3))) begin
        op_data_c = ~BACKGROUND;
      end
    end else begin
      // Reads of logical 1 happen in E2 and E4.
      if ((elem == ELEM_WIDTH'(2)) || (elem == ELEM_WIDTH'(4))) begin
        op_data_c = ~BACKGROUND;
      end
    end
  end

  always_comb begin
    last_addr_c = 1'b0;
    step_c      = 1'b0;
    miscmp_c    = 1'b0;
    halt_c      = 1'b0;

    last_addr_c = down_c ? (addr == '0) : (addr == ADDR_MAX);
    step_c      = !two_op_c || phase;
    miscmp_c    = cmp_valid && (sram_dout != cmp_exp);
    halt_c      = STOP_ON_FAIL && miscmp_c;
  end

  // Port mux; a halting miscompare also suppresses the write issued in that cycle.
  always_comb begin
    sram_we   = func_we;
    sram_addr = func_addr;
    sram_din  = func_din;
    if (busy) begin
      sram_we   = (state == RUN) && op_we_c && !halt_c;
      sram_addr = addr;
      sram_din  = op_data_c;
    end
  end

  // Sequencer, compare pipeline and result logging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      elem       <= '0;
      phase      <= 1'b0;
      addr       <= '0;
      start_q    <= 1'b0;
      cmp_valid  <= 1'b0;
      cmp_exp    <= '0;
      cmp_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_count <= '0;
    end else begin
      start_q   <= 1'b0;
      cmp_valid <= 1'b0;

      if (miscmp_c) begin
        fail <= 1'b1;
        if (!fail) begin
          fail_addr <= cmp_addr;
        end
        if (fail_count != CNT_MAX) begin
          fail_count <= fail_count + FAIL_CNT_WIDTH'(1);
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start_q) begin
            state <= RUN;
            busy  <= 1'b1;
            elem  <= '0;
            phase <= 1'b0;
            addr  <= '0;
          end else if (start) begin
            start_q    <= 1'b1;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_count <= '0;
          end
        end

        RUN: begin
          if (halt_c) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cmp_valid <= !op_we_c;
            cmp_exp   <= op_data_c;
            cmp_addr  <= addr;
            if (step_c) begin
              phase <= 1'b0;
              if (last_addr_c) begin
                if (elem == ELEM_LAST) begin
                  state <= DRAIN;
                end else begin
                  elem <= elem + ELEM_WIDTH'(1);
                  addr <= next_down_c ? ADDR_MAX : '0;
                end
              end else begin
                addr <= down_c ? (addr - ADDR_WIDTH'(1)) : (addr + ADDR_WIDTH'(1));
              end
            end else begin
              phase <= 1'b1;
            end
          end
        end

        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_march_bist.sv
// Directed bench for march_bist: default-size engine with a stuck-at RAM model,
// plus a 4-word instance whose operation trace is checked op by op.
`timescale 1ns/1ps

module tb_march_bist;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 4;
  localparam int unsigned FW  = 8;
  localparam int unsigned AWS = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start, func_we, sram_we, busy, done, fail;
  logic [AW-1:0] func_addr, sram_addr, fail_addr;
  logic [DW-1:0] func_din, sram_din, sram_dout;
  logic [FW-1:0] fail_count;

  logic           start_s, sram_we_s, busy_s, done_s, fail_s;
  logic           func_we_s;
  logic [AWS-1:0] func_addr_s, sram_addr_s, fail_addr_s;
  logic [DW-1:0]  func_din_s, sram_din_s, sram_dout_s;
  logic [FW-1:0]  fail_count_s;

  assign func_we_s   = 1'b0;
  assign func_addr_s = '0;
  assign func_din_s  = '0;

  march_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .func_we(func_we), .func_addr(func_addr), .func_din(func_din),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr), .fail_count(fail_count)
  );

  march_bist #(.ADDR_WIDTH(AWS), .DATA_WIDTH(DW), .BACKGROUND(4'b0101), .FAIL_CNT_WIDTH(FW)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s),
    .func_we(func_we_s), .func_addr(func_addr_s), .func_din(func_din_s),
    .sram_we(sram_we_s), .sram_addr(sram_addr_s), .sram_din(sram_din_s), .sram_dout(sram_dout_s),
    .busy(busy_s), .done(done_s), .fail(fail_s), .fail_addr(fail_addr_s), .fail_count(fail_count_s)
  );

  // RAM models: registered read data, optional bit-0 stuck-at-1 at 0x3C.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] dout_q;
  logic [AW-1:0] raddr_q;
  logic          fault_en;
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_din;
    dout_q  <= mem[sram_addr];
    raddr_q <= sram_addr;
  end
  assign sram_dout = dout_q | DW'(fault_en && (raddr_q == 8'h3C));

  logic [DW-1:0] mem_s [0:3];
  logic [DW-1:0] dout_s_q;
  always @(posedge clk) begin
    if (sram_we_s) mem_s[sram_addr_s] <= sram_din_s;
    dout_s_q <= mem_s[sram_addr_s];
  end
  assign sram_dout_s = dout_s_q;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_main();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs the default engine to done; counts edges, busy cycles and BIST writes.
  task automatic run_main(input bit poke, output int cyc, output int bcyc, output int wcyc);
    cyc = 0; bcyc = 0; wcyc = 0;
    while (!done && cyc < 3000) begin
      tick();
      cyc++;
      if (busy) begin
        bcyc++;
        if (sram_we) wcyc++;
      end
      start = (poke && cyc == 500);
    end
    start = 1'b0;
    check("run_reaches_done", 32'(done), 32'd1);
  endtask

  logic [6:0] exp_q[$];
  logic [6:0] obs;
  logic [3:0] bgs;
  int         a, nb, cyc, bcyc, wcyc;

  initial begin
    rst_n = 1'b0; start = 1'b0; start_s = 1'b0; fault_en = 1'b0;
    func_we = 1'b1; func_addr = 8'h12; func_din = 4'hA;
    repeat (2) @(posedge clk);
    #1;

    check("rst_busy",       32'(busy),       32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_fail",       32'(fail),       32'd0);
    check("rst_fail_addr",  32'(fail_addr),  32'd0);
    check("rst_fail_count", 32'(fail_count), 32'd0);
    check("rst_busy_small", 32'(busy_s),     32'd0);
    check("idle_mux_we",    32'(sram_we),    32'd1);
    check("idle_mux_addr",  32'(sram_addr),  32'h12);
    check("idle_mux_din",   32'(sram_din),   32'hA);

    rst_n = 1'b1;
    func_we = 1'b0;
    tick();

    // Small instance: expected March C- op trace with background 0101.
    bgs = 4'b0101;
    for (int el = 0; el < 6; el++) begin
      for (int i = 0; i < 4; i++) begin
        a = (el == 3 || el == 4) ? 3 - i : i;
        if (el == 0) begin
          exp_q.push_back({1'b1, 2'(a), bgs});
        end else begin
          exp_q.push_back({1'b0, 2'(a), 4'h0});
          if (el < 5) exp_q.push_back({1'b1, 2'(a), (el == 1 || el == 3) ? ~bgs : bgs});
        end
      end
    end
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    nb = 0; cyc = 0;
    while (!done_s && cyc < 100) begin
      tick();
      cyc++;
      if (busy_s) begin
        obs = {sram_we_s, sram_addr_s, sram_we_s ? sram_din_s : 4'h0};
        if (nb < 40) check($sformatf("trace_op%0d", nb), 32'(obs), 32'(exp_q[nb]));
        nb++;
      end
    end
    check("small_busy_cycles", 32'(nb),     32'd41);
    check("small_done_edge",   32'(cyc),    32'd42);
    check("small_fail",        32'(fail_s), 32'd0);

    // Fault-free default run; functional port driven and a start poked mid-run.
    func_we = 1'b1; func_addr = 8'hFF; func_din = 4'hF;
    start_main();
    check("start_busy_lag", 32'(busy), 32'd0);
    run_main(1'b1, cyc, bcyc, wcyc);
    func_we = 1'b0;
    check("clean_done_edge",  32'(cyc),        32'd2562);
    check("clean_busy_cyc",   32'(bcyc),       32'd2561);
    check("clean_writes",     32'(wcyc),       32'd1280);
    check("clean_fail",       32'(fail),       32'd0);
    check("clean_fail_count", 32'(fail_count), 32'd0);
    check("clean_fail_addr",  32'(fail_addr),  32'd0);
    check("clean_busy_end",   32'(busy),       32'd0);

    // Bit 0 stuck-at-1 at 0x3C; restart from DONE.
    fault_en = 1'b1;
    start_main();
    check("restart_clears_done", 32'(done), 32'd0);
    run_main(1'b0, cyc, bcyc, wcyc);
    check("fault_fail",      32'(fail),      32'd1);
    check("fault_fail_addr", 32'(fail_addr), 32'h3C);
`ifdef BIST_STOP_ON_FAIL_EN
    check("fault_done_edge",  32'(cyc),        32'd379);
    check("fault_writes",     32'(wcyc),       32'd316);
    check("fault_fail_count", 32'(fail_count), 32'd1);
`else
    check("fault_done_edge",  32'(cyc),        32'd2562);
    check("fault_writes",     32'(wcyc),       32'd1280);
    check("fault_fail_count", 32'(fail_count), 32'd3);
`endif

    // Reset 1000 cycles into a run, then a clean rerun.
    start_main();
    repeat (1000) tick();
    check("midrun_fail_set", 32'(fail), 32'd1);
    func_addr = 8'h55;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",       32'(busy),       32'd0);
    check("midrst_done",       32'(done),       32'd0);
    check("midrst_fail",       32'(fail),       32'd0);
    check("midrst_fail_addr",  32'(fail_addr),  32'd0);
    check("midrst_fail_count", 32'(fail_count), 32'd0);
    check("midrst_mux_addr",   32'(sram_addr),  32'h55);
    tick();
    rst_n = 1'b1;
    fault_en = 1'b0;
    tick();
    start_main();
    run_main(1'b0, cyc, bcyc, wcyc);
    check("rerun_done_edge",  32'(cyc),        32'd2562);
    check("rerun_fail",       32'(fail),       32'd0);
    check("rerun_fail_count", 32'(fail_count), 32'd0);

    // Functional write then read at 0x12 after the BIST.
    func_we = 1'b1; func_addr = 8'h12; func_din = 4'hA;
    #1;
    check("func_we",   32'(sram_we),   32'd1);
    check("func_addr", 32'(sram_addr), 32'h12);
    check("func_din",  32'(sram_din),  32'hA);
    tick();
    func_we = 1'b0;
    tick();
    check("func_readback", 32'(sram_dout), 32'hA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/march_bist.md
Name: march_bist

Overview:
- Parametrised March C- built-in self-test engine for a synchronous single-port SRAM; successor to the fixed-width checkerboard BIST.
- Sits between the functional SRAM port and the RAM macro. Muxes functional/BIST access, generates the March sequence (up/down addressing, configurable data background), compares read data, and logs failures.

Parameters:
- ADDR_WIDTH, 8, SRAM address width; depth N = 2**ADDR_WIDTH.
- DATA_WIDTH, 4, SRAM word width.
- BACKGROUND, {DATA_WIDTH{1'b0}}, pattern written as logical "0"; logical "1" = ~BACKGROUND.
- FAIL_CNT_WIDTH, 8, width of the saturating miscompare counter.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, starts a test when sampled high while not busy.
- func_we, input, 1, functional write enable.
- func_addr, input, ADDR_WIDTH, functional address.
- func_din, input, DATA_WIDTH, functional write data.
- sram_we, output, 1, to RAM: write enable.
- sram_addr, output, ADDR_WIDTH, to RAM: address.
- sram_din, output, DATA_WIDTH, to RAM: write data.
- sram_dout, input, DATA_WIDTH, from RAM: read data, valid the cycle after the address is presented.
- busy, output, 1, high while a test runs (RUN or DRAIN).
- done, output, 1, test complete; held until the next start or reset.
- fail, output, 1, sticky: at least one miscompare in the current or last test.
- fail_addr, output, ADDR_WIDTH, address of the first miscompare.
- fail_count, output, FAIL_CNT_WIDTH, number of miscompares, saturating at all-ones.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, fail=0, fail_addr=0, fail_count=0; internal counters cleared. sram_* follow func_* combinationally.
- Port mux: busy=0 gives sram_we/addr/din = func_we/addr/din. busy=1 gives BIST-driven values, and functional inputs are ignored.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE: start=1 at edge E0 → RUN. Clears done, fail, fail_addr, fail_count; element=0, addr=0.
  - RUN: one RAM op per cycle → DRAIN after the last op.
  - DRAIN: one cycle for the final read compare → DONE, done=1, busy=0.
- March C- elements, where 0 = BACKGROUND and 1 = ~BACKGROUND:
  - E0 up (w0)
  - E1 up (r0,w1)
  - E2 up (r1,w0)
  - E3 down (r0,w1)
  - E4 down (r1,w0)
  - E5 up (r0)
- Element ordering and addressing:
  - Single-op elements take 1 cycle per address. Two-op elements take 2 cycles per address: read then write, same address.
  - Up elements run address 0..N-1; down elements run N-1..0. The address counter wraps/reloads at element boundaries with no idle cycle.
- Cycle counts:
  - Total RUN cycles = 10N (2560 at defaults).
  - done rises on edge E0+10N+2.
  - busy is high from edge E0+1 through E0+10N+1.
- Compare pipeline: each read registers {valid, expected, addr}. On the next cycle sram_dout is compared against expected. Mismatch (any bit) with valid=1:
  - fail_count increments, saturating at all-ones;
  - fail is set;
  - fail_addr is loaded only if fail was 0 before that edge.
- Write cycles: no compare.
- start while busy: ignored.
- start in DONE: restarts and clears results.
- Reset mid-run: immediate abort to IDLE with all outputs at reset values. The RAM contents are left undefined.

Optional Feature:
- BIST_STOP_ON_FAIL_EN defined: on the first miscompare the FSM goes to DONE on the following edge. No further RAM ops are issued, fail_count=1, and done=1 early.
- Not defined: the full sequence always completes and every miscompare is counted.

Test Plan:
- Fault-free RAM model, defaults, start pulse at E0 → busy high for 2561 cycles, done at E0+2562, fail=0, fail_count=0, fail_addr=0.
- Data bit 0 stuck-at-1 at address 0x3C, BACKGROUND=0 → fail=1, fail_addr=0x3C, fail_count=3 (r0 in E1, E3, E5).
- Same fault with BIST_STOP_ON_FAIL_EN → done asserted during E1, fail_count=1, fail_addr=0x3C, no sram_we after the failing read.
- ADDR_WIDTH=2, DATA_WIDTH=4, BACKGROUND=4'b0101 → sram_addr/we/din trace is exactly:
  - 0,1,2,3 (w 0101);
  - then (r,w 1010) at 0,1,2,3;
  - ... then down order 3,2,1,0 for E3/E4;
  - 40 ops total.
- Idle functional mode: func_we=1, func_addr=0x12, func_din=0xA → identical values on sram_* the same cycle. After the BIST completes, the functional write/read at 0x12 returns 0xA.
- rst_n low at cycle 1000 of RUN, then start again → outputs at reset values during reset; the second run completes fault-free with fail=0.
